alu_operand_stage: RTL

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage.sv | 89 ++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand select/forward pipeline register feeding the ALU; define FORWARDING_EN to build the EX/MEM and MEM/WB bypass muxes
module alu_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            CLOCK,
    input  logic            RESET_N,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            src_a_pc,
    input  logic            src_b_imm,
    input  logic [3:0]      alu_op,
    input  logic [4:0]      rd_addr,
    input  logic            reg_write,
    input  logic            flush,
    input  logic            fwd_exmem_we,
    input  logic            fwd_memwb_we,
    input  logic [4:0]      fwd_exmem_rd,
    input  logic [4:0]      fwd_memwb_rd,
    input  logic [XLEN-1:0] fwd_exmem_data,
    input  logic [XLEN-1:0] fwd_memwb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [3:0]      ALU_control,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            illegal_op
);
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            accept, illegal;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign illegal  = alu_op > 4'd9;

`ifdef FORWARDING_EN
    // x0 is hardwired; the younger EX/MEM result beats MEM/WB
    always_comb begin
        rs1_val = rs1_addr == 5'd0 ? '0 :
                  (fwd_exmem_we && fwd_exmem_rd == rs1_addr) ? fwd_exmem_data :
                  (fwd_memwb_we && fwd_memwb_rd == rs1_addr) ? fwd_memwb_data : rs1_data;
        rs2_val = rs2_addr == 5'd0 ? '0 :
                  (fwd_exmem_we && fwd_exmem_rd == rs2_addr) ? fwd_exmem_data :
                  (fwd_memwb_we && fwd_memwb_rd == rs2_addr) ? fwd_memwb_data : rs2_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_exmem_we, fwd_memwb_we, fwd_exmem_rd, fwd_memwb_rd,
                          fwd_exmem_data, fwd_memwb_data};
    // no bypass: x0 reads as zero, everything else straight from the register file
    always_comb begin
        rs1_val = rs1_addr == 5'd0 ? '0 : rs1_data;
        rs2_val = rs2_addr == 5'd0 ? '0 : rs2_data;
    end
`endif

    // pipeline register: flush beats capture, capture beats drain, otherwise hold
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_valid     <= 1'b0;
            A             <= '0;
            B             <= '0;
            ALU_control   <= 4'd0;
            out_rd        <= 5'd0;
            out_reg_write <= 1'b0;
            illegal_op    <= 1'b0;
        end else if (flush) begin
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            A             <= src_a_pc ? pc : rs1_val;
            B             <= src_b_imm ? imm : rs2_val;
            ALU_control   <= illegal ? 4'd0 : alu_op;
            out_rd        <= rd_addr;
            out_reg_write <= !illegal && reg_write && rd_addr != 5'd0;
            illegal_op    <= illegal;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end
endmodule
